// File: rtl/pmem_line_server.sv
// Program-memory line server: assembles 128-bit fetch lines from a 32-bit
// instruction store through a single-line buffer with hit/miss statistics.
module pmem_line_server #(
    parameter int LINE_WORDS = 4,
    parameter int CNT_W      = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    p_mem_req,
    input  logic [31:0]             p_mem_add,
    output logic                    p_mem_ready,
    output logic                    p_mem_valid,
    output logic [LINE_WORDS*32-1:0] p_mem_data,
    input  logic                    flush,
    output logic [31:0]             b_mem_add,
    input  logic [31:0]             b_mem_data,
    output logic [CNT_W-1:0]        hit_cnt,
    output logic [CNT_W-1:0]        miss_cnt
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FILL,
        ST_RESP
    } state_t;

    state_t                  state_q, state_d;
    logic [27:0]             buf_tag_q, buf_tag_d;
    logic                    buf_vld_q, buf_vld_d;
    logic [LINE_WORDS*32-1:0] buf_data_q, buf_data_d;
    logic [1:0]              idx_q, idx_d;
    logic [27:0]             req_tag_q, req_tag_d;
    logic                    fill_flush_q, fill_flush_d;
    logic [31:0]             b_mem_add_q, b_mem_add_d;
    logic                    ready_q, ready_d;
    logic                    valid_q, valid_d;
    logic [CNT_W-1:0]        hit_cnt_q, hit_cnt_d;
    logic [CNT_W-1:0]        miss_cnt_q, miss_cnt_d;

    logic                    accept;
    logic                    is_hit;

    assign accept = p_mem_req && ready_q;
    // Hit test uses the pre-flush valid bit, so a same-cycle flush still lets this request hit.
    assign is_hit = buf_vld_q && (buf_tag_q == p_mem_add[31:4]);

    always_comb begin
        state_d      = state_q;
        buf_tag_d    = buf_tag_q;
        buf_vld_d    = buf_vld_q;
        buf_data_d   = buf_data_q;
        idx_d        = idx_q;
        req_tag_d    = req_tag_q;
        fill_flush_d = fill_flush_q;
        b_mem_add_d  = b_mem_add_q;
        hit_cnt_d    = hit_cnt_q;
        miss_cnt_d   = miss_cnt_q;

        case (state_q)
            ST_IDLE: begin
                if (flush) begin
                    buf_vld_d = 1'b0;
                end
                if (accept) begin
                    if (is_hit) begin
                        state_d   = ST_RESP;
                        hit_cnt_d = (&hit_cnt_q) ? hit_cnt_q : hit_cnt_q + CNT_W'(1);
                    end else begin
                        state_d      = ST_FILL;
                        req_tag_d    = p_mem_add[31:4];
                        idx_d        = 2'd0;
                        buf_vld_d    = 1'b0;
                        fill_flush_d = 1'b0;
                        b_mem_add_d  = {p_mem_add[31:4], 2'd0, 2'b00};
                        miss_cnt_d   = (&miss_cnt_q) ? miss_cnt_q : miss_cnt_q + CNT_W'(1);
                    end
                end
            end
            ST_FILL: begin
                buf_data_d[idx_q*32 +: 32] = b_mem_data;
                idx_d = idx_q + 2'd1;
                if (flush) begin
                    fill_flush_d = 1'b1;
                end
                if (idx_q == 2'd3) begin
                    // A flush seen anywhere in the fill leaves the new line unusable for later hits.
                    buf_tag_d = req_tag_q;
                    buf_vld_d = !(fill_flush_q || flush);
                    state_d   = ST_RESP;
                end else begin
                    b_mem_add_d = {req_tag_q, idx_q + 2'd1, 2'b00};
                end
            end
            ST_RESP: begin
                if (flush) begin
                    buf_vld_d = 1'b0;
                end
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        ready_d = (state_d == ST_IDLE);
        valid_d = (state_d == ST_RESP);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            buf_tag_q    <= '0;
            buf_vld_q    <= 1'b0;
            buf_data_q   <= '0;
            idx_q        <= 2'd0;
            req_tag_q    <= '0;
            fill_flush_q <= 1'b0;
            b_mem_add_q  <= '0;
            ready_q      <= 1'b1;
            valid_q      <= 1'b0;
            hit_cnt_q    <= '0;
            miss_cnt_q   <= '0;
        end else begin
            state_q      <= state_d;
            buf_tag_q    <= buf_tag_d;
            buf_vld_q    <= buf_vld_d;
            buf_data_q   <= buf_data_d;
            idx_q        <= idx_d;
            req_tag_q    <= req_tag_d;
            fill_flush_q <= fill_flush_d;
            b_mem_add_q  <= b_mem_add_d;
            ready_q      <= ready_d;
            valid_q      <= valid_d;
            hit_cnt_q    <= hit_cnt_d;
            miss_cnt_q   <= miss_cnt_d;
        end
    end

    assign p_mem_ready = ready_q;
    assign p_mem_valid = valid_q;
    assign p_mem_data  = buf_data_q;
    assign b_mem_add   = b_mem_add_q;
    assign hit_cnt     = hit_cnt_q;
    assign miss_cnt    = miss_cnt_q;

endmodule

// File: tb/tb_pmem_line_server.sv
// Directed bench for pmem_line_server: table of fetch requests plus hand-written
// sequences for held requests, mid-fill reset and counter saturation.
module tb_pmem_line_server;

    localparam int CNT_W = 4;

    logic         clk;
    logic         rst;
    logic         p_mem_req;
    logic [31:0]  p_mem_add;
    logic         p_mem_ready;
    logic         p_mem_valid;
    logic [127:0] p_mem_data;
    logic         flush;
    logic [31:0]  b_mem_add;
    logic [31:0]  b_mem_data;
    logic [CNT_W-1:0] hit_cnt;
    logic [CNT_W-1:0] miss_cnt;

    int total;
    int bad;

    pmem_line_server #(.LINE_WORDS(4), .CNT_W(CNT_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .p_mem_req   (p_mem_req),
        .p_mem_add   (p_mem_add),
        .p_mem_ready (p_mem_ready),
        .p_mem_valid (p_mem_valid),
        .p_mem_data  (p_mem_data),
        .flush       (flush),
        .b_mem_add   (b_mem_add),
        .b_mem_data  (b_mem_data),
        .hit_cnt     (hit_cnt),
        .miss_cnt    (miss_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Backing store: word at byte address 0x100+4i holds 0xA0+i.
    assign b_mem_data = (b_mem_add >> 2) + 32'h60;

    typedef struct {
        logic [31:0] addr;
        int          flush_k;
        int          lat;
        int          hit;
        int          miss;
    } vec_t;

    vec_t tbl[11];

    function automatic logic [127:0] line_of(input logic [31:0] addr);
        logic [127:0] l;
        logic [31:0]  a;
        for (int i = 0; i < 4; i++) begin
            a = {addr[31:4], 2'(i), 2'b00};
            l[32*i +: 32] = (a >> 2) + 32'h60;
        end
        return l;
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one request from IDLE and follow it through to ready again.
    task automatic issue(input logic [31:0] addr, input int flush_k, input int lat,
                         input int ehit, input int emiss, input string tag);
        logic [31:0] prev_b;
        logic [1:0]  kk;
        prev_b    = b_mem_add;
        p_mem_add = addr;
        p_mem_req = 1'b1;
        flush     = (flush_k == 0);
        check({tag, " ready_at_req"}, 128'(p_mem_ready), 128'd1);
        step();
        p_mem_req = 1'b0;
        flush     = 1'b0;
        p_mem_add = 32'hDEAD_BEE0;
        for (int k = 1; k <= lat + 1; k++) begin
            check({tag, " valid"}, 128'(p_mem_valid), 128'(k == lat));
            check({tag, " ready"}, 128'(p_mem_ready), 128'(k == lat + 1));
            if (k == lat)
                check({tag, " data"}, p_mem_data, line_of(addr));
            if (lat == 1) begin
                check({tag, " b_add_hold"}, 128'(b_mem_add), 128'(prev_b));
            end else begin
                kk = (k <= 4) ? 2'(k - 1) : 2'd3;
                check({tag, " b_add"}, 128'(b_mem_add), 128'({addr[31:4], kk, 2'b00}));
            end
            if (k <= lat) begin
                flush = (k == flush_k);
                step();
                flush = 1'b0;
            end
        end
        check({tag, " hit_cnt"}, 128'(hit_cnt), 128'(ehit));
        check({tag, " miss_cnt"}, 128'(miss_cnt), 128'(emiss));
        $display("req %s addr=%h lat=%0d hit_cnt=%0d miss_cnt=%0d", tag, addr, lat, hit_cnt, miss_cnt);
    endtask

    initial begin
        total     = 0;
        bad       = 0;
        rst       = 1'b1;
        p_mem_req = 1'b0;
        p_mem_add = 32'h0;
        flush     = 1'b0;

        tbl[0]  = '{32'h104, -1, 5, 0, 1};   // cold miss
        tbl[1]  = '{32'h10C, -1, 1, 1, 1};   // hit same line
        tbl[2]  = '{32'h200,  2, 5, 1, 2};   // flush in 2nd FILL cycle
        tbl[3]  = '{32'h200, -1, 5, 1, 3};   // misses because flushed
        tbl[4]  = '{32'h208, -1, 1, 2, 3};
        tbl[5]  = '{32'h204,  0, 1, 3, 3};   // same-cycle flush, still hits
        tbl[6]  = '{32'h200, -1, 5, 3, 4};
        tbl[7]  = '{32'h20C,  1, 1, 4, 4};   // flush during RESP
        tbl[8]  = '{32'h200, -1, 5, 4, 5};
        tbl[9]  = '{32'h100,  4, 5, 4, 6};   // flush in last FILL cycle
        tbl[10] = '{32'h100, -1, 5, 4, 7};

        step();
        step();
        step();
        rst = 1'b0;
        check("rst ready", 128'(p_mem_ready), 128'd1);
        check("rst valid", 128'(p_mem_valid), 128'd0);
        check("rst data", p_mem_data, 128'd0);
        check("rst b_add", 128'(b_mem_add), 128'd0);
        check("rst hit", 128'(hit_cnt), 128'd0);
        check("rst miss", 128'(miss_cnt), 128'd0);

        for (int i = 0; i < 11; i++)
            issue(tbl[i].addr, tbl[i].flush_k, tbl[i].lat, tbl[i].hit, tbl[i].miss, $sformatf("vec%0d", i));

        // Held request: 0x300 accepted, next request held during the whole fill.
        p_mem_add = 32'h300;
        p_mem_req = 1'b1;
        check("held ready0", 128'(p_mem_ready), 128'd1);
        step();
        p_mem_add = 32'h310;
        for (int k = 1; k <= 5; k++) begin
            check("held ready_low", 128'(p_mem_ready), 128'd0);
            check("held no_dup", 128'(miss_cnt), 128'd8);
            check("held valid", 128'(p_mem_valid), 128'(k == 5));
            if (k <= 4)
                check("held b_add", 128'(b_mem_add), 128'({28'h30, 2'(k - 1), 2'b00}));
            else
                check("held data", p_mem_data, line_of(32'h300));
            step();
        end
        $display("req held addr=300 lat=5 hit_cnt=%0d miss_cnt=%0d", hit_cnt, miss_cnt);
        issue(32'h310, -1, 5, 4, 9, "held2");
        for (int k = 0; k < 3; k++) begin
            check("held idle_valid", 128'(p_mem_valid), 128'd0);
            check("held idle_miss", 128'(miss_cnt), 128'd9);
            step();
        end

        // Reset in the third FILL cycle aborts without a response.
        p_mem_add = 32'h400;
        p_mem_req = 1'b1;
        step();
        p_mem_req = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            check("rstfill valid", 128'(p_mem_valid), 128'd0);
            rst = (k == 3);
            step();
        end
        rst = 1'b0;
        check("rstfill valid_after", 128'(p_mem_valid), 128'd0);
        check("rstfill ready", 128'(p_mem_ready), 128'd1);
        check("rstfill hit", 128'(hit_cnt), 128'd0);
        check("rstfill miss", 128'(miss_cnt), 128'd0);
        check("rstfill b_add", 128'(b_mem_add), 128'd0);
        check("rstfill data", p_mem_data, 128'd0);
        $display("req rst_mid_fill addr=400 aborted");
        issue(32'h400, -1, 5, 0, 1, "after_rst");

        // Hit counter saturation at 4'hF.
        for (int i = 1; i <= 16; i++)
            issue(32'h404, -1, 1, (i > 15) ? 15 : i, 1, $sformatf("sat%0d", i));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
